// File: rtl/pdp8_pkg.sv
// Shared PDP-8 datapath types and widths used by the memory arbiter.
package pdp8_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;

  typedef enum logic [1:0] {
    SRC_IFU,
    SRC_EXEC_RD,
    SRC_EXEC_WR
  } mem_src_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

endpackage

// File: rtl/pdp_mem_prio_sel.sv
// Combinational grant selector: fixed priority wr > rd > ifu, except that a
// starved IFU wins once the exec burst limit has been reached.
module pdp_mem_prio_sel
  import pdp8_pkg::*;
#(
  parameter int MAX_EXEC_BURST = 4
) (
  input  logic       ifu_rd_req,
  input  logic       exec_rd_req,
  input  logic       exec_wr_req,
  input  logic [2:0] burst_cnt,
  output logic       grant_valid,
  output mem_src_e   grant_src
);

  always_comb begin
    grant_valid = ifu_rd_req | exec_rd_req | exec_wr_req;
    grant_src   = SRC_IFU;
    if (ifu_rd_req && (burst_cnt == 3'(MAX_EXEC_BURST)))
      grant_src = SRC_IFU;
    else if (exec_wr_req)
      grant_src = SRC_EXEC_WR;
    else if (exec_rd_req)
      grant_src = SRC_EXEC_RD;
    else
      grant_src = SRC_IFU;
  end

endmodule

// File: rtl/pdp_mem_arbiter.sv
// Arbitrates the IFU read port and the exec read/write ports onto a single
// single-port synchronous SRAM. Every output is driven straight from a flop.
module pdp_mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int READ_LATENCY   = 1,
  parameter int MAX_EXEC_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic                  ifu_rd_ack,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic                  exec_rd_ack,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  arb_state_e            state, state_next;
  mem_src_e              src, grant_src;
  logic                  grant_valid, grant;
  logic [2:0]            burst_cnt, lat_cnt;
  logic [ADDR_WIDTH-1:0] addr_q, grant_addr;
  logic [DATA_WIDTH-1:0] wdata_q;

  pdp_mem_prio_sel #(.MAX_EXEC_BURST(MAX_EXEC_BURST)) u_prio_sel (
    .ifu_rd_req (ifu_rd_req),
    .exec_rd_req(exec_rd_req),
    .exec_wr_req(exec_wr_req),
    .burst_cnt  (burst_cnt),
    .grant_valid(grant_valid),
    .grant_src  (grant_src)
  );

  assign grant     = (state == IDLE) && grant_valid;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    grant_addr = ifu_rd_addr;
    case (grant_src)
      SRC_EXEC_WR: grant_addr = exec_wr_addr;
      SRC_EXEC_RD: grant_addr = exec_rd_addr;
      default:     grant_addr = ifu_rd_addr;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = (src == SRC_EXEC_WR) ? RESP : WAIT;
      WAIT:    if (lat_cnt == 3'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with it while staying registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      ifu_rd_ack  <= 1'b0;
      exec_rd_ack <= 1'b0;
      exec_wr_ack <= 1'b0;
    end else begin
      state       <= state_next;
      mem_en      <= (state_next == ISSUE);
      mem_we      <= grant && (grant_src == SRC_EXEC_WR);
      ifu_rd_ack  <= (state_next == RESP) && (src == SRC_IFU);
      exec_rd_ack <= (state_next == RESP) && (src == SRC_EXEC_RD);
      exec_wr_ack <= (state_next == RESP) && (src == SRC_EXEC_WR);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src     <= SRC_IFU;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      src     <= grant_src;
      addr_q  <= grant_addr;
      wdata_q <= exec_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt      <= 3'd0;
      ifu_rd_data  <= '0;
      exec_rd_data <= '0;
    end else begin
      if (state == ISSUE)
        lat_cnt <= 3'(READ_LATENCY - 1);
      else if ((state == WAIT) && (lat_cnt != 3'd0))
        lat_cnt <= lat_cnt - 3'd1;
      if ((state == WAIT) && (lat_cnt == 3'd0)) begin
        if (src == SRC_IFU)
          ifu_rd_data <= mem_rdata;
        else
          exec_rd_data <= mem_rdata;
      end
    end
  end

  // Counts exec grants that made a waiting IFU request stand aside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= 3'd0;
    end else if (state == IDLE) begin
      if (!ifu_rd_req || (grant_valid && (grant_src == SRC_IFU)))
        burst_cnt <= 3'd0;
      else if (grant_valid && (burst_cnt != 3'(MAX_EXEC_BURST)))
        burst_cnt <= burst_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Self-checking bench for pdp_mem_arbiter: one instance with READ_LATENCY=1
// and one with READ_LATENCY=3, each backed by a small behavioural SRAM.
module tb_pdp_mem_arbiter;
  import pdp8_pkg::*;

  typedef enum logic [1:0] {K_IFU, K_RD, K_WR} kind_e;

  typedef struct {
    kind_e       kind;
    logic [11:0] addr;
    logic [11:0] wdata;
    logic [11:0] exp_data;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ifu_rd_req, exec_rd_req, exec_wr_req;
  logic [11:0] ifu_rd_addr, exec_rd_addr, exec_wr_addr, exec_wr_data;
  logic        ifu_rd_ack, exec_rd_ack, exec_wr_ack, mem_en, mem_we;
  logic [11:0] ifu_rd_data, exec_rd_data, mem_addr, mem_wdata, mem_rdata;

  logic        ifu_rd_req3, exec_rd_req3, exec_wr_req3;
  logic [11:0] ifu_rd_addr3, exec_rd_addr3, exec_wr_addr3, exec_wr_data3;
  logic        ifu_rd_ack3, exec_rd_ack3, exec_wr_ack3, mem_en3, mem_we3;
  logic [11:0] ifu_rd_data3, exec_rd_data3, mem_addr3, mem_wdata3, mem_rdata3;

  pdp_mem_arbiter #(.READ_LATENCY(1), .MAX_EXEC_BURST(4)) dut1 (
    .clk(clk), .reset(reset),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_ack(ifu_rd_ack), .ifu_rd_data(ifu_rd_data),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
    .exec_rd_ack(exec_rd_ack), .exec_rd_data(exec_rd_data),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr),
    .exec_wr_data(exec_wr_data), .exec_wr_ack(exec_wr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  pdp_mem_arbiter #(.READ_LATENCY(3), .MAX_EXEC_BURST(4)) dut3 (
    .clk(clk), .reset(reset),
    .ifu_rd_req(ifu_rd_req3), .ifu_rd_addr(ifu_rd_addr3),
    .ifu_rd_ack(ifu_rd_ack3), .ifu_rd_data(ifu_rd_data3),
    .exec_rd_req(exec_rd_req3), .exec_rd_addr(exec_rd_addr3),
    .exec_rd_ack(exec_rd_ack3), .exec_rd_data(exec_rd_data3),
    .exec_wr_req(exec_wr_req3), .exec_wr_addr(exec_wr_addr3),
    .exec_wr_data(exec_wr_data3), .exec_wr_ack(exec_wr_ack3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // One-cycle SRAM for dut1 and a three-stage read pipeline for dut3.
  bit   [11:0] mem1 [4096];
  bit   [11:0] mem3 [4096];
  logic [11:0] p1, p2, p3;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem1[mem_addr] <= mem_wdata;
      mem_rdata <= mem1[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
    if (mem_en3) p1 <= mem3[mem_addr3];
    p2 <= p1;
    p3 <= p2;
  end
  assign mem_rdata3 = p3;

  int multi_ack = 0;
  always @(negedge clk) begin
    if ($countones({ifu_rd_ack, exec_rd_ack, exec_wr_ack}) > 1) multi_ack++;
    if ($countones({ifu_rd_ack3, exec_rd_ack3, exec_wr_ack3}) > 1) multi_ack++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0o required=%0o", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit sel3, input kind_e k, input logic r,
                           input logic [11:0] a, input logic [11:0] d);
    if (sel3) begin
      case (k)
        K_IFU:   begin ifu_rd_req3 = r; ifu_rd_addr3 = a; end
        K_RD:    begin exec_rd_req3 = r; exec_rd_addr3 = a; end
        default: begin exec_wr_req3 = r; exec_wr_addr3 = a; exec_wr_data3 = d; end
      endcase
    end else begin
      case (k)
        K_IFU:   begin ifu_rd_req = r; ifu_rd_addr = a; end
        K_RD:    begin exec_rd_req = r; exec_rd_addr = a; end
        default: begin exec_wr_req = r; exec_wr_addr = a; exec_wr_data = d; end
      endcase
    end
  endtask

  // Runs one access; cycle 0 is the IDLE cycle that samples the request.
  task automatic apply_stimulus(input bit sel3, input vec_t v, input string name,
                                input bit chg, input logic [11:0] chg_addr);
    bit         done = 1'b0;
    logic [2:0] acks, exp_acks;
    exp_acks = (v.kind == K_IFU) ? 3'b100 : (v.kind == K_RD) ? 3'b010 : 3'b001;
    @(posedge clk); #1;
    drive_req(sel3, v.kind, 1'b1, v.addr, v.wdata);
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      acks = sel3 ? {ifu_rd_ack3, exec_rd_ack3, exec_wr_ack3}
                  : {ifu_rd_ack, exec_rd_ack, exec_wr_ack};
      if (cyc == 1) begin
        check_output({name, "_en"}, sel3 ? mem_en3 : mem_en, 1);
        check_output({name, "_we"}, sel3 ? mem_we3 : mem_we, v.kind == K_WR);
        check_output({name, "_maddr"}, sel3 ? mem_addr3 : mem_addr, v.addr);
        if (v.kind == K_WR)
          check_output({name, "_mwdata"}, sel3 ? mem_wdata3 : mem_wdata, v.wdata);
        if (chg) drive_req(sel3, v.kind, 1'b1, chg_addr, v.wdata);
      end
      if (acks != 3'b000) begin
        check_output({name, "_ack"}, acks, exp_acks);
        check_output({name, "_lat"}, cyc, v.exp_lat);
        if (v.kind == K_IFU)
          check_output({name, "_data"}, sel3 ? ifu_rd_data3 : ifu_rd_data, v.exp_data);
        else if (v.kind == K_RD)
          check_output({name, "_data"}, sel3 ? exec_rd_data3 : exec_rd_data, v.exp_data);
        drive_req(sel3, v.kind, 1'b0, v.addr, v.wdata);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: actual=no ack required=ack within 20 cycles", name);
    end
  endtask

  vec_t tbl [8];
  int   n_acks, acks_seen, lat;
  int   order [5];
  int   when  [5];

  initial begin
    tbl[0] = '{K_WR,  12'o0200, 12'o7402, 12'o0000, 2};
    tbl[1] = '{K_RD,  12'o0200, 12'o0000, 12'o7402, 3};
    tbl[2] = '{K_IFU, 12'o0200, 12'o0000, 12'o7402, 3};
    tbl[3] = '{K_WR,  12'o0017, 12'o0055, 12'o0000, 2};
    tbl[4] = '{K_RD,  12'o0000, 12'o0000, 12'o0000, 3};
    tbl[5] = '{K_WR,  12'o7777, 12'o7777, 12'o0000, 2};
    tbl[6] = '{K_RD,  12'o7777, 12'o0000, 12'o7777, 3};
    tbl[7] = '{K_IFU, 12'o0017, 12'o0000, 12'o0055, 3};

    reset = 1'b1;
    {ifu_rd_req, exec_rd_req, exec_wr_req} = 3'b000;
    {ifu_rd_addr, exec_rd_addr, exec_wr_addr, exec_wr_data} = '0;
    {ifu_rd_req3, exec_rd_req3, exec_wr_req3} = 3'b000;
    {ifu_rd_addr3, exec_rd_addr3, exec_wr_addr3, exec_wr_data3} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_acks", {ifu_rd_ack, exec_rd_ack, exec_wr_ack}, 0);
    check_output("rst_mem_ctl", {mem_en, mem_we}, 0);
    check_output("rst_mem_bus", {mem_addr, mem_wdata}, 0);
    check_output("rst_rdata", {ifu_rd_data, exec_rd_data}, 0);
    check_output("rst_state", 32'(dut1.state), 32'(IDLE));
    check_output("rst_cnts", {dut1.burst_cnt, dut1.lat_cnt}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      apply_stimulus(1'b0, tbl[i], $sformatf("vec%0d", i), 1'b0, 12'o0);
    check_output("rd_data_hold", exec_rd_data, 12'o7777);

    // All three requesters at once: write, then exec read, then IFU.
    @(posedge clk); #1;
    exec_wr_addr = 12'o0300; exec_wr_data = 12'o1111; exec_rd_addr = 12'o0300;
    ifu_rd_addr = 12'o0200;
    {ifu_rd_req, exec_rd_req, exec_wr_req} = 3'b111;
    n_acks = 0;
    for (int i = 0; i < 5; i++) begin order[i] = -1; when[i] = -1; end
    for (int cyc = 0; cyc < 40 && n_acks < 3; cyc++) begin
      @(negedge clk);
      if (exec_wr_ack) begin order[n_acks] = 0; when[n_acks] = cyc; n_acks++; exec_wr_req = 1'b0; end
      if (exec_rd_ack) begin order[n_acks] = 1; when[n_acks] = cyc; n_acks++; exec_rd_req = 1'b0; end
      if (ifu_rd_ack)  begin order[n_acks] = 2; when[n_acks] = cyc; n_acks++; ifu_rd_req  = 1'b0; end
    end
    {ifu_rd_req, exec_rd_req, exec_wr_req} = 3'b000;
    check_output("sim_n_acks", n_acks, 3);
    check_output("sim_order", {order[0][7:0], order[1][7:0], order[2][7:0]}, 24'h000102);
    check_output("sim_times", {when[0][7:0], when[1][7:0], when[2][7:0]}, 24'h02060a);
    check_output("sim_rd_data", exec_rd_data, 12'o1111);
    check_output("sim_ifu_data", ifu_rd_data, 12'o7402);

    // IFU held against a back-to-back exec read stream.
    @(posedge clk); #1;
    exec_rd_addr = 12'o0200; ifu_rd_addr = 12'o0017;
    exec_rd_req = 1'b1; ifu_rd_req = 1'b1;
    n_acks = 0;
    for (int i = 0; i < 5; i++) begin order[i] = -1; when[i] = -1; end
    for (int cyc = 0; cyc < 60 && n_acks < 5; cyc++) begin
      @(negedge clk);
      if (exec_rd_ack || ifu_rd_ack) begin
        order[n_acks] = ifu_rd_ack ? 2 : 1;
        when[n_acks]  = cyc;
        if (n_acks == 3) check_output("burst_cnt_sat", dut1.burst_cnt, 4);
        if (ifu_rd_ack) begin
          check_output("burst_cnt_clr", dut1.burst_cnt, 0);
          check_output("burst_ifu_data", ifu_rd_data, 12'o0055);
          {ifu_rd_req, exec_rd_req} = 2'b00;
        end
        n_acks++;
      end
    end
    {ifu_rd_req, exec_rd_req} = 2'b00;
    check_output("burst_n_acks", n_acks, 5);
    check_output("burst_order", {order[0][3:0], order[1][3:0], order[2][3:0],
                                 order[3][3:0], order[4][3:0]}, 20'h11112);
    check_output("burst_ifu_time", when[4], 19);

    // Reset during WAIT of an exec read, then the requester reissues it.
    @(posedge clk); #1;
    exec_rd_addr = 12'o0200; exec_rd_req = 1'b1;
    @(negedge clk); @(negedge clk);
    check_output("rstw_issue_en", mem_en, 1);
    @(negedge clk);
    check_output("rstw_in_wait", 32'(dut1.state), 32'(WAIT));
    reset = 1'b1; #1;
    check_output("rstw_en", mem_en, 0);
    check_output("rstw_state", 32'(dut1.state), 32'(IDLE));
    acks_seen = 0;
    repeat (3) begin
      @(negedge clk);
      acks_seen += $countones({ifu_rd_ack, exec_rd_ack, exec_wr_ack});
    end
    check_output("rstw_no_ack", acks_seen, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    lat = -1;
    for (int cyc = 0; cyc < 20 && lat < 0; cyc++) begin
      @(negedge clk);
      if (exec_rd_ack) begin lat = cyc; exec_rd_req = 1'b0; end
    end
    exec_rd_req = 1'b0;
    check_output("rstw_reissue_lat", lat, 3);
    check_output("rstw_reissue_data", exec_rd_data, 12'o7402);

    // Reset during ISSUE of a write drops the strobes before the SRAM edge.
    @(posedge clk); #1;
    exec_wr_addr = 12'o0400; exec_wr_data = 12'o5555; exec_wr_req = 1'b1;
    @(negedge clk); @(negedge clk);
    check_output("rsti_we_before", {mem_en, mem_we}, 2'b11);
    reset = 1'b1; #1;
    check_output("rsti_we_after", {mem_en, mem_we}, 2'b00);
    exec_wr_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    apply_stimulus(1'b0, '{K_RD, 12'o0400, 12'o0, 12'o0000, 3}, "rsti_lost_wr", 1'b0, 12'o0);

    // Address moved by the requester mid-access is ignored.
    apply_stimulus(1'b0, '{K_RD, 12'o0200, 12'o0, 12'o7402, 3}, "addr_chg", 1'b1, 12'o0017);

    // Three-cycle SRAM: preload, then IFU read returns five cycles later.
    apply_stimulus(1'b1, '{K_WR, 12'o0000, 12'o1234, 12'o0, 2}, "rl3_wr", 1'b0, 12'o0);
    apply_stimulus(1'b1, '{K_IFU, 12'o0000, 12'o0, 12'o1234, 5}, "rl3_ifu", 1'b0, 12'o0);
    check_output("rl3_exec_data_idle", exec_rd_data3, 12'o0000);

    check_output("no_double_ack", multi_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
